// File: rtl/sipo_nibble_packer_if.sv
// rtl/sipo_nibble_packer_if.sv - nibble-in / word-out handshake bundle for sipo_nibble_packer
//
// Purpose: groups the nibble input, flush/clear controls and the word-output
// valid/ready handshake of the packer into one port.
// Signals:
//   nib_i        4        parallel nibble from the SIPO stage
//   nib_valid_i  1        one-cycle strobe, nib_i is fresh
//   flush_i      1        zero-pad the partial word and push it
//   word_ready_i 1        consumer accepts word_o this cycle
//   clr_ovf_i    1        clears overflow_o
//   word_o       W        FIFO head word
//   word_valid_o 1        FIFO not empty
//   count_o      CW       FIFO occupancy, 0..DEPTH
//   overflow_o   1        sticky, a completed word was dropped
// Modports: master drives the inputs of the packer, slave is the packer.
interface sipo_nibble_packer_if #(
   parameter int NIBBLES = 4,
   parameter int DEPTH   = 4
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [3:0]    nib_i;
   logic          nib_valid_i;
   logic          flush_i;
   logic          word_ready_i;
   logic          clr_ovf_i;
   logic [W-1:0]  word_o;
   logic          word_valid_o;
   logic [CW-1:0] count_o;
   logic          overflow_o;

   modport master (
      output nib_i, nib_valid_i, flush_i, word_ready_i, clr_ovf_i,
      input  word_o, word_valid_o, count_o, overflow_o
   );

   modport slave (
      input  nib_i, nib_valid_i, flush_i, word_ready_i, clr_ovf_i,
      output word_o, word_valid_o, count_o, overflow_o
   );
endinterface

// File: rtl/sipo_nibble_packer.sv
// rtl/sipo_nibble_packer.sv - packs SIPO nibbles MSN-first into words behind a FWFT FIFO
//
// Purpose: collects NIBBLES successive nibbles into a W-bit word (first nibble
// in the top bits), pushes completed or flushed (zero-padded) words into a
// DEPTH-entry first-word-fall-through FIFO, and presents the head word on a
// valid/ready handshake. Words that find the FIFO full (and no pop in the
// same cycle) are dropped and flagged on a sticky overflow bit.
// Ports:
//   wb_clk_i  single clock, rising edge
//   wb_rst_n  asynchronous active-low reset
//   bus       sipo_nibble_packer_if.slave (nibble in, word out, status)
module sipo_nibble_packer #(
   parameter int NIBBLES = 4,
   parameter int DEPTH   = 4
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n,
   sipo_nibble_packer_if.slave   bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [IW-1:0] idx;
   logic [W-1:0]  acc;
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          ovf;

   logic [W-1:0]  acc_ins;
   logic [W-1:0]  push_word;
   logic          last_nib;
   logic          push;
   logic          pop;
   logic          full;
   logic          accept;
   logic          drop;

   always_comb begin
      // Unwritten acc bits are always zero, so OR-ing the nibble in is exact
      // and a padded word can never carry stale data.
      acc_ins   = acc | (W'(bus.nib_i) << (W - 4 - 4 * int'(idx)));
      last_nib  = (idx == IW'(NIBBLES - 1));
      // A flush together with a nibble still yields exactly one push.
      push      = (bus.nib_valid_i && last_nib) ||
                  (bus.flush_i && (bus.nib_valid_i || idx != '0));
      push_word = bus.nib_valid_i ? acc_ins : acc;
      pop       = (count != '0) && bus.word_ready_i;
      full      = (count == CW'(DEPTH));
      // A full FIFO still takes the word when its head leaves in the same cycle.
      accept    = push && (!full || pop);
      drop      = push && !accept;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         idx    <= '0;
         acc    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         // Packer: a push (accepted or dropped) always restarts the word.
         if (push) begin
            idx <= '0;
            acc <= '0;
         end else if (bus.nib_valid_i) begin
            idx <= idx + IW'(1);
            acc <= acc_ins;
         end

         if (accept) begin
            mem[wr_ptr] <= push_word;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end

         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         // A drop in the same cycle as a clear keeps the flag set.
         if (drop) begin
            ovf <= 1'b1;
         end else if (bus.clr_ovf_i) begin
            ovf <= 1'b0;
         end
      end
   end

   assign bus.word_o       = mem[rd_ptr];
   assign bus.word_valid_o = (count != '0);
   assign bus.count_o      = count;
   assign bus.overflow_o   = ovf;
endmodule

// File: tb/tb_sipo_nibble_packer.sv
// tb/tb_sipo_nibble_packer.sv - table-driven self-checking bench for sipo_nibble_packer
module tb_sipo_nibble_packer;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   sipo_nibble_packer_if #(.NIBBLES(4), .DEPTH(4)) bus ();

   sipo_nibble_packer #(.NIBBLES(4), .DEPTH(4)) dut (
      .wb_clk_i (clk),
      .wb_rst_n (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  nib;
      logic        nv;
      logic        fl;
      logic        rdy;
      logic        clr;
      logic [15:0] ew;
      logic        ev;
      logic [2:0]  ec;
      logic        eo;
      logic        cw;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic addv(input logic [3:0] nib, input logic nv, input logic fl,
                       input logic rdy, input logic clr, input logic [15:0] ew,
                       input logic ev, input int ec, input logic eo, input logic cw);
      vec_t v;
      v.nib = nib; v.nv = nv; v.fl = fl; v.rdy = rdy; v.clr = clr;
      v.ew = ew; v.ev = ev; v.ec = 3'(ec); v.eo = eo; v.cw = cw;
      vecs.push_back(v);
   endtask

   // Four strobes of nibble k; ready/clear only on the completing strobe.
   task automatic add_word(input logic [3:0] k, input logic rdy_last, input logic clr_last,
                           input logic [15:0] head_before, input logic [15:0] head_after,
                           input int cnt_before, input int cnt_after,
                           input logic ovf_before, input logic ovf_after);
      for (int n = 0; n < 3; n++)
         addv(k, 1, 0, 0, 0, head_before, cnt_before > 0, cnt_before, ovf_before, cnt_before > 0);
      addv(k, 1, 0, rdy_last, clr_last, head_after, cnt_after > 0, cnt_after, ovf_after, cnt_after > 0);
   endtask

   task automatic drive(input logic [3:0] nib, input logic nv, input logic fl,
                        input logic rdy, input logic clr);
      bus.nib_i        = nib;
      bus.nib_valid_i  = nv;
      bus.flush_i      = fl;
      bus.word_ready_i = rdy;
      bus.clr_ovf_i    = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      drive(4'h0, 0, 0, 0, 0);
      rst_n = 1'b1;

      // Basic packing, pop, flush padding, idle flush
      addv(4'hA, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
      addv(4'hB, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
      addv(4'hC, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
      addv(4'hD, 1, 0, 0, 0, 16'hABCD, 1, 1, 0, 1);
      addv(4'h0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
      addv(4'h5, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
      addv(4'h6, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
      addv(4'h0, 0, 1, 0, 0, 16'h5600, 1, 1, 0, 1);
      addv(4'h0, 0, 1, 0, 0, 16'h5600, 1, 1, 0, 1);
      addv(4'h0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
      // Same-cycle flush: padded partial word, then completing nibble + flush
      addv(4'h1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
      addv(4'h2, 1, 1, 0, 0, 16'h1200, 1, 1, 0, 1);
      addv(4'h3, 1, 0, 0, 0, 16'h1200, 1, 1, 0, 1);
      addv(4'h4, 1, 0, 0, 0, 16'h1200, 1, 1, 0, 1);
      addv(4'h5, 1, 0, 0, 0, 16'h1200, 1, 1, 0, 1);
      addv(4'h6, 1, 1, 0, 0, 16'h1200, 1, 2, 0, 1);
      addv(4'h0, 0, 0, 1, 0, 16'h3456, 1, 1, 0, 1);
      addv(4'h0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
      // Overflow: fifth word dropped, then drain and clear
      add_word(4'h1, 0, 0, 16'h0000, 16'h1111, 0, 1, 0, 0);
      add_word(4'h2, 0, 0, 16'h1111, 16'h1111, 1, 2, 0, 0);
      add_word(4'h3, 0, 0, 16'h1111, 16'h1111, 2, 3, 0, 0);
      add_word(4'h4, 0, 0, 16'h1111, 16'h1111, 3, 4, 0, 0);
      add_word(4'h5, 0, 0, 16'h1111, 16'h1111, 4, 4, 0, 1);
      addv(4'h0, 0, 0, 1, 0, 16'h2222, 1, 3, 1, 1);
      addv(4'h0, 0, 0, 1, 0, 16'h3333, 1, 2, 1, 1);
      addv(4'h0, 0, 0, 1, 0, 16'h4444, 1, 1, 1, 1);
      addv(4'h0, 0, 0, 1, 0, 16'h0000, 0, 0, 1, 0);
      addv(4'h0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0);
      // Full FIFO with a pop in the completing cycle: no drop
      add_word(4'h1, 0, 0, 16'h0000, 16'h1111, 0, 1, 0, 0);
      add_word(4'h2, 0, 0, 16'h1111, 16'h1111, 1, 2, 0, 0);
      add_word(4'h3, 0, 0, 16'h1111, 16'h1111, 2, 3, 0, 0);
      add_word(4'h4, 0, 0, 16'h1111, 16'h1111, 3, 4, 0, 0);
      add_word(4'h5, 1, 0, 16'h1111, 16'h2222, 4, 4, 0, 0);
      addv(4'h0, 0, 0, 1, 0, 16'h3333, 1, 3, 0, 1);
      addv(4'h0, 0, 0, 1, 0, 16'h4444, 1, 2, 0, 1);
      addv(4'h0, 0, 0, 1, 0, 16'h5555, 1, 1, 0, 1);
      addv(4'h0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
      addv(4'h0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
      // Drop in the same cycle as clear: overflow wins
      add_word(4'h6, 0, 0, 16'h0000, 16'h6666, 0, 1, 0, 0);
      add_word(4'h7, 0, 0, 16'h6666, 16'h6666, 1, 2, 0, 0);
      add_word(4'h8, 0, 0, 16'h6666, 16'h6666, 2, 3, 0, 0);
      add_word(4'h9, 0, 0, 16'h6666, 16'h6666, 3, 4, 0, 0);
      add_word(4'hA, 0, 1, 16'h6666, 16'h6666, 4, 4, 0, 1);
      addv(4'h0, 0, 0, 0, 1, 16'h6666, 1, 4, 0, 1);
      // Leave count=3, idx=2 for the asynchronous reset
      addv(4'h0, 0, 0, 1, 0, 16'h7777, 1, 3, 0, 1);
      addv(4'h1, 1, 0, 0, 0, 16'h7777, 1, 3, 0, 1);
      addv(4'h2, 1, 0, 0, 0, 16'h7777, 1, 3, 0, 1);

      #1 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_word",  32'(bus.word_o),       32'h0);
      check("reset_valid", 32'(bus.word_valid_o), 32'h0);
      check("reset_count", 32'(bus.count_o),      32'h0);
      check("reset_ovf",   32'(bus.overflow_o),   32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].nib, vecs[i].nv, vecs[i].fl, vecs[i].rdy, vecs[i].clr);
         tick();
         check($sformatf("row%0d_valid", i), 32'(bus.word_valid_o), 32'(vecs[i].ev));
         check($sformatf("row%0d_count", i), 32'(bus.count_o),      32'(vecs[i].ec));
         check($sformatf("row%0d_ovf", i),   32'(bus.overflow_o),   32'(vecs[i].eo));
         if (vecs[i].cw)
            check($sformatf("row%0d_word", i), 32'(bus.word_o), 32'(vecs[i].ew));
      end

      // Asynchronous reset between edges, mid-word with a non-empty FIFO
      drive(4'h0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_word",  32'(bus.word_o),       32'h0);
      check("async_valid", 32'(bus.word_valid_o), 32'h0);
      check("async_count", 32'(bus.count_o),      32'h0);
      check("async_ovf",   32'(bus.overflow_o),   32'h0);
      tick();
      rst_n = 1'b1;
      drive(4'h9, 1, 0, 0, 0); tick();
      drive(4'h8, 1, 0, 0, 0); tick();
      drive(4'h7, 1, 0, 0, 0); tick();
      check("post_reset_no_residue_count", 32'(bus.count_o), 32'h0);
      drive(4'h6, 1, 0, 0, 0); tick();
      drive(4'h0, 0, 0, 0, 0);
      check("post_reset_word",  32'(bus.word_o),       32'h9876);
      check("post_reset_valid", 32'(bus.word_valid_o), 32'h1);
      check("post_reset_count", 32'(bus.count_o),      32'h1);
      check("post_reset_ovf",   32'(bus.overflow_o),   32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sipo_nibble_packer.md
# sipo_nibble_packer

Downstream consumer of the 4-bit serial-in/parallel-out stage in the user project. It collects successive parallel nibbles from the SIPO into 16-bit words, most-significant nibble first. Completed words are buffered in a small first-word-fall-through FIFO and presented on a valid/ready handshake. Later logic (Wishbone or LA readout) pops the words at its own pace.

## Interface
- NIBBLES, 4: nibbles per output word; word width W = 4*NIBBLES (16 by default).
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- nib_i  in  4  parallel nibble from the SIPO stage.
- nib_valid_i  in  1  one-cycle strobe; nib_i holds a fresh nibble.
- flush_i  in  1  zero-pad the partial word and push it.
- word_o  out  W  FIFO head word.
- word_valid_o  out  1  FIFO not empty.
- word_ready_i  in  1  consumer accepts word_o this cycle.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- overflow_o  out  1  sticky; a completed word was dropped.
- clr_ovf_i  in  1  clears overflow_o.

## Operation
- Packer state:
  - Nibble index idx, range 0..NIBBLES-1.
  - Shift register acc, width W.
- On nib_valid_i:
  - nib_i is placed at bits [W-1-4*idx -: 4], so the first nibble lands in word[15:12].
  - idx increments.
  - On the nibble at idx = NIBBLES-1, the full word is pushed and idx returns to 0.
- flush_i with idx > 0 and no nib_valid_i:
  - Unfilled nibble positions are zero.
  - The word is pushed and idx returns to 0.
- flush_i with idx = 0: no-op, nothing pushed.
- flush_i and nib_valid_i in the same cycle:
  - The nibble is inserted first.
  - If that nibble completes the word, it is a normal push.
  - Otherwise the word with that nibble is zero-padded and pushed.
  - Result: exactly one push.
- acc bits not yet written are held at 0, so a padded word never contains stale data.
- FIFO:
  - Circular buffer of DEPTH entries; read/write pointers wrap modulo DEPTH.
  - Occupancy counter drives count_o.
- Pop: word_valid_o && word_ready_i at a clock edge. word_ready_i while empty has no effect.
- Push acceptance:
  - Accepted if count < DEPTH.
  - When count = DEPTH, accepted only if a pop occurs in the same cycle; occupancy stays DEPTH.
  - Otherwise the word is dropped, overflow_o sets, and idx still returns to 0.
- Simultaneous push and pop with count = 0 is impossible, because word_valid_o = 0.
- Simultaneous push and pop with 0 < count < DEPTH: occupancy is unchanged.
- overflow_o stays set until clr_ovf_i. A new drop in the same cycle as clr_ovf_i wins, so overflow_o stays 1.
- word_o = mem[rd_ptr] (first-word fall-through). It is don't-care while word_valid_o = 0 but must not be X after reset; memory resets to 0.

## Timing
- Reset (wb_rst_n low, asynchronous):
  - word_o = 0, word_valid_o = 0, count_o = 0, overflow_o = 0.
  - idx = 0, acc = 0, both pointers = 0.
  - Deassertion is synchronous to wb_clk_i from the system-level synchronizer.
- Reset mid-word: the partial word is discarded and not pushed.
- Reset with a non-empty FIFO: contents are lost.
- Latency: completing nibble or flush accepted at edge N into an empty FIFO → word_valid_o = 1 and word_o valid from edge N (visible in cycle N+1).
- Pop at edge N → the next entry is on word_o from edge N, and count_o decrements at the same edge.
- Throughput:
  - One nibble per cycle.
  - One push per cycle maximum.
  - One pop per cycle.
- All outputs are registered or decode directly from registered state; there is no combinational path from word_ready_i to word_valid_o.

## Test plan
- Reset check: after reset, all outputs are 0. Strobe nibbles 0xA, 0xB, 0xC, 0xD on consecutive cycles with word_ready_i = 0 → word_o = 0xABCD, word_valid_o = 1 from the edge of the 4th strobe, count_o = 1.
- Flush padding: nibbles 0x5, 0x6, then flush_i → word 0x5600. A flush with idx = 0 → count_o unchanged.
- Same-cycle flush: nib 0x1 at idx 0, then nib 0x2 together with flush_i → single word 0x1200. A 4th nibble together with flush_i → single normal word, no extra push.
- Overflow: with word_ready_i = 0, push 5 words (0x1111..0x5555) → count_o = 4, overflow_o = 1, FIFO holds 0x1111..0x4444. Pop all in order. clr_ovf_i → overflow_o = 0.
- Full push and pop: FIFO full, word_ready_i = 1 in the cycle the 5th word completes → no overflow, count_o stays 4, order 0x2222..0x5555. Drop asserted in the same cycle as clr_ovf_i → overflow_o remains 1.
- Async reset mid-operation: pull wb_rst_n low between clock edges with idx = 2 and count_o = 3 → all outputs 0 immediately. After release, nibbles 0x9, 0x8, 0x7, 0x6 → 0x9876 with no residue from the old state.
